// File: rtl/core_mem_stage.sv
// rtl/core_mem_stage.sv - RISC-V MEM stage: dmem req/gnt/rvalid port, store lane alignment, load extraction
// Optional feature macro MEM_STORE_ACK_EN: stores wait for dmem_rvalid_i as a write acknowledge.
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 7'b0000011
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 7'b0100011
`endif

module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_reg_write_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misaligned_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;

    logic            is_load_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [1:0]      lane_q;

    logic            is_load, is_store, is_mem, misaligned;
    logic [1:0]      size;
    logic [1:0]      a;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign ex_ready_o = (state == IDLE);

    // size: 0 byte, 1 half, 2 word; unlisted funct3 encodings fall back to word
    always_comb begin
        is_load  = (opcode_i == `OPCODE_LOAD);
        is_store = (opcode_i == `OPCODE_STORE);
        is_mem   = is_load | is_store;
        a        = alu_result_i[1:0];
        case (funct3_i)
            3'b000:  size = 2'd0;
            3'b001:  size = 2'd1;
            3'b100:  size = is_load ? 2'd0 : 2'd2;
            3'b101:  size = is_load ? 2'd1 : 2'd2;
            default: size = 2'd2;
        endcase
        misaligned = ((size == 2'd1) && a[0]) || ((size == 2'd2) && (|a));
        case (size)
            2'd0: begin
                be    = 4'b0001 << a;
                wdata = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << {a[1], 1'b0};
                wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data_i;
            end
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            is_load_q      <= 1'b0;
            funct3_q       <= '0;
            rd_q           <= '0;
            lane_q         <= '0;
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            dmem_be_o      <= '0;
            dmem_addr_o    <= '0;
            dmem_wdata_o   <= '0;
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            misaligned_o   <= 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            misaligned_o   <= 1'b0;
            case (state)
                IDLE: if (ex_valid_i) begin
                    is_load_q <= is_load;
                    funct3_q  <= funct3_i;
                    rd_q      <= rd_i;
                    lane_q    <= a;
                    if (!is_mem) begin
                        wb_valid_o     <= 1'b1;
                        wb_data_o      <= alu_result_i;
                        wb_reg_write_o <= |rd_i;
                        wb_rd_o        <= rd_i;
                    end else if (misaligned) begin
                        wb_valid_o   <= 1'b1;
                        misaligned_o <= 1'b1;
                        wb_rd_o      <= rd_i;
                    end else begin
                        state        <= REQ;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= is_store;
                        dmem_be_o    <= be;
                        dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
                        dmem_wdata_o <= is_store ? wdata : '0;
                    end
                end
                REQ: if (dmem_gnt_i) begin
                    dmem_req_o <= 1'b0;
                    dmem_we_o  <= 1'b0;
                    dmem_be_o  <= '0;
                    if (is_load_q) begin
                        state <= WAIT;
                    end else begin
`ifdef MEM_STORE_ACK_EN
                        state <= WAIT;
`else
                        state      <= IDLE;
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd_q;
`endif
                    end
                end
                WAIT: if (dmem_rvalid_i) begin
                    state      <= IDLE;
                    wb_valid_o <= 1'b1;
                    wb_rd_o    <= rd_q;
                    if (is_load_q) begin
                        wb_data_o      <= ld_data;
                        wb_reg_write_o <= |rd_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_stage.sv
// tb/tb_core_mem_stage.sv - self-checking bench for core_mem_stage: directed scenarios plus randomized ops vs reference model
module tb_core_mem_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        wb_valid, wb_reg_write, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_mem_stage #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
        .opcode_i(opcode), .funct3_i(funct3), .rd_i(rd), .alu_result_i(alu_result),
        .store_data_i(store_data), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_be_o(dmem_be), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .wb_valid_o(wb_valid), .wb_reg_write_o(wb_reg_write), .wb_rd_o(wb_rd),
        .wb_data_o(wb_data), .misaligned_o(misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes, from the ISA meaning of funct3
    function automatic int acc_size(bit ld, logic [2:0] f3);
        if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic int low_byte(int sz, logic [1:0] a);
        if (sz == 4) return 0;
        if (sz == 2) return (int'(a) / 2) * 2;
        return int'(a);
    endfunction

    function automatic logic [3:0] exp_be(int sz, logic [1:0] a);
        logic [3:0] m;
        int lo;
        m = '0;
        lo = low_byte(sz, a);
        for (int i = 0; i < sz; i++) m[lo + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(int sz, logic [31:0] d);
        if (sz == 1) return (d & 32'hff) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hffff) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(logic [2:0] f3, logic [1:0] a, logic [31:0] r);
        int sz;
        logic [31:0] mask, v;
        sz = acc_size(1'b1, f3);
        if (sz == 4) return r;
        mask = (sz == 1) ? 32'hff : 32'hffff;
        v = (r >> (8 * low_byte(sz, a))) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        tick(); tick();
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, misaligned} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%b be=%h addr=%h wdata=%h wbv=%b wbd=%h expected all zero", dmem_req, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_data);
        end
        n_checks++;
        if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_back_to_back();
        opcode = OP_ALU; funct3 = 3'd0; rd = 5'd5; alu_result = 32'h0000_1234; store_data = '0;
        ex_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready[%0d]: got %b expected 1", i, ex_ready); end
            tick();
            if (i == 2) ex_valid = 1'b0;
            n_checks++;
            if ({wb_valid, wb_reg_write, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
                n_fail++; $display("FAIL alu_wb[%0d]: got v=%b we=%b rd=%0d data=%h expected v=1 we=1 rd=5 data=00001234", i, wb_valid, wb_reg_write, wb_rd, wb_data);
            end
        end
        tick();
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_pulse_end: got %b expected 0", wb_valid); end
    endtask

    task automatic test_sb_gnt_delay();
        opcode = OP_STORE; funct3 = 3'd0; rd = 5'd0; alu_result = 32'h0000_0103; store_data = 32'hAABB_CCDD;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ex_ready, wb_valid} !== {1'b1, 1'b1, 4'b1000, 32'h100, 32'hDDDD_DDDD, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL sb_req[%0d]: got req=%b we=%b be=%b addr=%h wdata=%h rdy=%b wbv=%b expected req=1 we=1 be=1000 addr=00000100 wdata=dddddddd rdy=0 wbv=0", i, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ex_ready, wb_valid);
            end
            if (i == 2) gnt = 1'b1;
            tick();
        end
        gnt = 1'b0;
`ifdef MEM_STORE_ACK_EN
        n_checks++;
        if ({wb_valid, ex_ready} !== 2'b00) begin n_fail++; $display("FAIL sb_ack_wait: got wbv=%b rdy=%b expected 0 0", wb_valid, ex_ready); end
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
`endif
        n_checks++;
        if ({wb_valid, wb_reg_write, misaligned, dmem_req, ex_ready} !== 5'b10001) begin
            n_fail++; $display("FAIL sb_retire: got wbv=%b we=%b mis=%b req=%b rdy=%b expected 1 0 0 0 1", wb_valid, wb_reg_write, misaligned, dmem_req, ex_ready);
        end
        tick();
    endtask

    task automatic test_lb_lbu();
        logic [31:0] want;
        for (int k = 0; k < 2; k++) begin
            opcode = OP_LOAD; funct3 = (k == 0) ? 3'd0 : 3'd4; rd = 5'd7; alu_result = 32'h0000_0202;
            want = (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            ex_valid = 1'b1;
            tick();
            ex_valid = 1'b0;
            n_checks++;
            if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b0100, 32'h200}) begin
                n_fail++; $display("FAIL lb_req[%0d]: got req=%b we=%b be=%b addr=%h expected 1 0 0100 00000200", k, dmem_req, dmem_we, dmem_be, dmem_addr);
            end
            gnt = 1'b1;
            tick();
            gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0080_0000;
            tick();
            rvalid = 1'b0;
            n_checks++;
            if ({wb_valid, wb_reg_write, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd7, want}) begin
                n_fail++; $display("FAIL lb_data[%0d]: got v=%b we=%b rd=%0d data=%h expected v=1 we=1 rd=7 data=%h", k, wb_valid, wb_reg_write, wb_rd, wb_data, want);
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
        opcode = OP_LOAD; funct3 = 3'd1; rd = 5'd3; alu_result = 32'h0000_0301;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if ({dmem_req, wb_valid, misaligned, wb_reg_write, ex_ready} !== 5'b01101) begin
            n_fail++; $display("FAIL lh_misaligned: got req=%b wbv=%b mis=%b we=%b rdy=%b expected 0 1 1 0 1", dmem_req, wb_valid, misaligned, wb_reg_write, ex_ready);
        end
        tick();
        n_checks++;
        if ({wb_valid, misaligned, dmem_req} !== 3'b000) begin
            n_fail++; $display("FAIL lh_misaligned_pulse: got wbv=%b mis=%b req=%b expected 0 0 0", wb_valid, misaligned, dmem_req);
        end
    endtask

    task automatic test_lw_rd0();
        opcode = OP_LOAD; funct3 = 3'd2; rd = 5'd0; alu_result = 32'h0000_0400;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b1111, 32'h400}) begin
            n_fail++; $display("FAIL lw_req: got req=%b be=%b addr=%h expected 1 1111 00000400", dmem_req, dmem_be, dmem_addr);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_reg_write, wb_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL lw_rd0: got v=%b we=%b data=%h expected v=1 we=0 data=deadbeef", wb_valid, wb_reg_write, wb_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        opcode = OP_LOAD; funct3 = 3'd2; rd = 5'd9; alu_result = 32'h0000_0500;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0; gnt = 1'b1;
        tick();
        gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, misaligned, ex_ready} !== {{107{1'b0}}, 1'b1}) begin
            n_fail++; $display("FAIL rst_wait_outputs: got req=%b addr=%h wbv=%b wbd=%h rdy=%b expected zeros and rdy=1", dmem_req, dmem_addr, wb_valid, wb_data, ex_ready);
        end
        rvalid = 1'b1; rdata = $urandom;
        tick();
        rvalid = 1'b0;
        n_checks++;
        if ({wb_valid, ex_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_wait_rvalid: got wbv=%b rdy=%b expected 0 1", wb_valid, ex_ready); end
        // reset while still requesting drops the request next cycle
        opcode = OP_STORE; funct3 = 3'd2; alu_result = 32'h0000_0600; store_data = $urandom;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({dmem_req, ex_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_req: got req=%b rdy=%b expected 0 1", dmem_req, ex_ready); end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_gnt: got wbv=%b expected 0", wb_valid); end
    endtask

    task automatic test_random();
        int kind, sz, gd, rdl;
        bit is_ld, is_st, is_mem, mis, wait_rv;
        logic [31:0] last_data, rd_val;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_data = '0;
        for (int n = 0; n < 200; n++) begin
            // bus noise while idle must be ignored
            gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
            tick();
            gnt = 1'b0; rvalid = 1'b0;
            n_checks++;
            if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_noise[%0d]: got wbv=%b expected 0", n, wb_valid); end
            kind = $urandom_range(0, 2);
            opcode = (kind == 0) ? OP_ALU : ((kind == 1) ? OP_LOAD : OP_STORE);
            funct3 = 3'($urandom); rd = 5'($urandom); alu_result = $urandom; store_data = $urandom;
            is_ld = (kind == 1); is_st = (kind == 2); is_mem = is_ld || is_st;
            sz = acc_size(is_ld, funct3);
            mis = is_mem && ((alu_result[1:0] % sz) != 0);
            n_checks++;
            if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected 1", n, ex_ready); end
            ex_valid = 1'b1;
            tick();
            ex_valid = 1'b0;
            if (!is_mem) begin
                last_data = alu_result;
                n_checks++;
                if ({wb_valid, wb_reg_write, wb_rd, wb_data, misaligned} !== {1'b1, rd != 5'd0, rd, alu_result, 1'b0}) begin
                    n_fail++; $display("FAIL rnd_alu[%0d]: got v=%b we=%b rd=%0d data=%h expected v=1 we=%b rd=%0d data=%h", n, wb_valid, wb_reg_write, wb_rd, wb_data, rd != 5'd0, rd, alu_result);
                end
            end else if (mis) begin
                n_checks++;
                if ({wb_valid, misaligned, wb_reg_write, dmem_req, wb_data} !== {4'b1100, last_data}) begin
                    n_fail++; $display("FAIL rnd_mis[%0d]: got v=%b mis=%b we=%b req=%b data=%h expected 1 1 0 0 data=%h", n, wb_valid, misaligned, wb_reg_write, dmem_req, wb_data, last_data);
                end
            end else begin
                gd = $urandom_range(0, 2);
                for (int i = 0; i <= gd; i++) begin
                    n_checks++;
                    if ({dmem_req, dmem_we, dmem_be, dmem_addr, ex_ready} !== {1'b1, is_st, exp_be(sz, alu_result[1:0]), alu_result & 32'hFFFF_FFFC, 1'b0}) begin
                        n_fail++; $display("FAIL rnd_req[%0d]: got req=%b we=%b be=%b addr=%h rdy=%b expected req=1 we=%b be=%b addr=%h rdy=0", n, dmem_req, dmem_we, dmem_be, dmem_addr, ex_ready, is_st, exp_be(sz, alu_result[1:0]), alu_result & 32'hFFFF_FFFC);
                    end
                    if (is_st) begin
                        n_checks++;
                        if (dmem_wdata !== exp_wdata(sz, store_data)) begin
                            n_fail++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, dmem_wdata, exp_wdata(sz, store_data));
                        end
                    end
                    if (i == gd) gnt = 1'b1;
                    tick();
                end
                gnt = 1'b0;
`ifdef MEM_STORE_ACK_EN
                wait_rv = 1'b1;
`else
                wait_rv = is_ld;
`endif
                if (wait_rv) begin
                    rdl = $urandom_range(0, 2);
                    for (int i = 0; i < rdl; i++) begin
                        n_checks++;
                        if ({wb_valid, ex_ready, dmem_req} !== 3'b000) begin
                            n_fail++; $display("FAIL rnd_wait[%0d]: got wbv=%b rdy=%b req=%b expected 0 0 0", n, wb_valid, ex_ready, dmem_req);
                        end
                        tick();
                    end
                    rd_val = $urandom;
                    rvalid = 1'b1; rdata = rd_val;
                    tick();
                    rvalid = 1'b0;
                end
                if (is_ld) last_data = exp_load(funct3, alu_result[1:0], rd_val);
                n_checks++;
                if ({wb_valid, wb_reg_write, misaligned, wb_data, ex_ready} !== {1'b1, is_ld && (rd != 5'd0), 1'b0, last_data, 1'b1}) begin
                    n_fail++; $display("FAIL rnd_retire[%0d]: got v=%b we=%b mis=%b data=%h rdy=%b expected v=1 we=%b mis=0 data=%h rdy=1", n, wb_valid, wb_reg_write, misaligned, wb_data, ex_ready, is_ld && (rd != 5'd0), last_data);
                end
                if (is_ld) begin
                    n_checks++;
                    if (wb_rd !== rd) begin n_fail++; $display("FAIL rnd_ld_rd[%0d]: got %0d expected %0d", n, wb_rd, rd); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_sb_gnt_delay();
        test_lb_lbu();
        test_misaligned();
        test_lw_rd0();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
